// File: rtl/fs_fifo_pkg.sv
// fs_fifo_pkg: shared sizing helpers for the synchronous FIFO.
//   FIFO_DEPTH_DEF : default number of FIFO entries
//   FIFO_CNT_W     : occupancy count width for the default depth (0..DEPTH)
//   fifo_cnt_w()   : occupancy count width for an arbitrary depth
package fs_fifo_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned FIFO_CNT_W     = $clog2(FIFO_DEPTH_DEF) + 1;

    // One extra bit so the count can represent DEPTH itself.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync2_ff.sv
// sync2_ff: two-flop synchroniser with edge detection.
//   clk : clock, all logic on rising edge
//   rst : synchronous, active-high reset (all flops load R)
//   d   : asynchronous input
//   q   : synchronised output (second flop)
//   pe  : one-cycle pulse on a rising edge of q
//   ne  : one-cycle pulse on a falling edge of q
module sync2_ff #(
    parameter logic R = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic pe,
    output logic ne
);

    logic meta;
    logic q_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= R;
            q      <= R;
            q_prev <= R;
        end else begin
            meta   <= d;
            q      <= meta;
            q_prev <= q;
        end
    end

    // q_prev resets to R as well, so leaving reset never produces a pulse.
    always_comb begin
        pe = q & ~q_prev;
        ne = ~q & q_prev;
    end

endmodule

// File: rtl/fs_fifo.sv
// fs_fifo: single-clock synchronous FIFO with registered read data.
//   clk_i     : clock, all logic on rising edge
//   reset_i   : synchronous, active-high reset (flushes FIFO, clears rd_data_o)
//   wr_i      : write strobe, accepted when !full_o
//   wr_data_i : write data
//   rd_i      : read strobe, accepted when !empty_o
//   rd_data_o : registered read data, updated one cycle after an accepted read
//   full_o    : filled_o == DEPTH
//   empty_o   : filled_o == 0
//   filled_o  : current occupancy 0..DEPTH
module fs_fifo
    import fs_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   filled_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full_o  = (filled_o == CNT_FULL);
        empty_o = (filled_o == '0);
        wr_en   = wr_i && !full_o;
        rd_en   = rd_i && !empty_o;
    end

    // Storage is not reset; writes during reset are suppressed so the
    // flush cycle leaves no trace.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_en) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            filled_o  <= '0;
            rd_data_o <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_data_o <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   filled_o <= filled_o + 1'b1;
                2'b01:   filled_o <= filled_o - 1'b1;
                default: filled_o <= filled_o;
            endcase
        end
    end

endmodule

// File: tb/tb_fs_fifo.sv
// tb_fs_fifo: directed test of fs_fifo with a queue scoreboard, plus sync2_ff.
module tb_fs_fifo;

    localparam int unsigned W = 16;
    localparam int unsigned D = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic [W-1:0]  wr_data;
    logic          rd;
    logic [W-1:0]  rd_data;
    logic          full;
    logic          empty;
    logic [4:0]    filled;

    logic          srst;
    logic          sd;
    logic          sq;
    logic          spe;
    logic          sne;

    int unsigned   n_assert = 0;
    int unsigned   n_fail   = 0;

    logic [W-1:0]  sb[$];
    logic [W-1:0]  last_rd;

    always #5 clk = ~clk;

    fs_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_i      (wr),
        .wr_data_i (wr_data),
        .rd_i      (rd),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .filled_o  (filled)
    );

    sync2_ff #(.R(1'b1)) u_sync (
        .clk (clk),
        .rst (srst),
        .d   (sd),
        .q   (sq),
        .pe  (spe),
        .ne  (sne)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check every output.
    task automatic cyc(input string tag, input logic r, input logic w,
                       input logic [W-1:0] wd, input logic rr);
        logic wa;
        logic ra;
        reset   = r;
        wr      = w;
        wr_data = wd;
        rd      = rr;
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            last_rd = '0;
        end else begin
            wa = w && (sb.size() < D);
            ra = rr && (sb.size() > 0);
            if (ra) last_rd = sb.pop_front();
            if (wa) sb.push_back(wd);
        end
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(last_rd));
        chk({tag, ".filled"},  32'(filled),  32'(sb.size()));
        chk({tag, ".full"},    32'(full),    32'(sb.size() == D));
        chk({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic scyc(input logic d);
        sd = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; wr_data = '0; rd = 1'b0;
        srst = 1'b1; sd = 1'b1;
        last_rd = '0;

        // reset state
        cyc("reset", 1'b1, 1'b0, '0, 1'b0);
        cyc("reset2", 1'b1, 1'b0, '0, 1'b0);
        chk("reset.filled0", 32'(filled), 32'd0);

        // three words in, three out
        cyc("w1", 1'b0, 1'b1, 16'h1111, 1'b0);
        cyc("w2", 1'b0, 1'b1, 16'h2222, 1'b0);
        cyc("w3", 1'b0, 1'b1, 16'h3333, 1'b0);
        chk("three.filled", 32'(filled), 32'd3);
        cyc("r1", 1'b0, 1'b0, '0, 1'b1);
        chk("r1.data", 32'(rd_data), 32'h1111);
        cyc("r2", 1'b0, 1'b0, '0, 1'b1);
        chk("r2.data", 32'(rd_data), 32'h2222);
        cyc("r3", 1'b0, 1'b0, '0, 1'b1);
        chk("r3.data", 32'(rd_data), 32'h3333);
        chk("r3.empty", 32'(empty), 32'd1);

        // fill to full, overflow write dropped
        for (int i = 0; i < 16; i++) cyc("fill", 1'b0, 1'b1, W'(i), 1'b0);
        chk("full.flag", 32'(full), 32'd1);
        chk("full.filled", 32'(filled), 32'd16);
        cyc("overflow", 1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk("overflow.filled", 32'(filled), 32'd16);
        // rd+wr while full: only the read happens
        cyc("rdwr_full", 1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("rdwr_full.filled", 32'(filled), 32'd15);
        chk("rdwr_full.data", 32'(rd_data), 32'h0000);
        for (int i = 1; i < 16; i++) begin
            cyc("drain", 1'b0, 1'b0, '0, 1'b1);
            chk("drain.data", 32'(rd_data), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // read on empty holds data
        cyc("wA", 1'b0, 1'b1, 16'hAAAA, 1'b0);
        cyc("rA", 1'b0, 1'b0, '0, 1'b1);
        cyc("rEmpty1", 1'b0, 1'b0, '0, 1'b1);
        cyc("rEmpty2", 1'b0, 1'b0, '0, 1'b1);
        chk("rEmpty.hold", 32'(rd_data), 32'hAAAA);
        chk("rEmpty.filled", 32'(filled), 32'd0);

        // rd+wr while empty: only the write happens
        cyc("rdwr_empty", 1'b0, 1'b1, 16'h5A5A, 1'b1);
        chk("rdwr_empty.filled", 32'(filled), 32'd1);
        chk("rdwr_empty.hold", 32'(rd_data), 32'hAAAA);

        // reach 5 entries, then steady rd+wr across pointer wrap
        for (int i = 0; i < 4; i++) cyc("pre5", 1'b0, 1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc("stream", 1'b0, 1'b1, W'($urandom), 1'b1);
            chk("stream.filled5", 32'(filled), 32'd5);
        end

        // mid-stream reset at 9 entries with a write pending
        for (int i = 0; i < 4; i++) cyc("pre9", 1'b0, 1'b1, W'($urandom), 1'b0);
        chk("pre9.filled", 32'(filled), 32'd9);
        cyc("midreset", 1'b1, 1'b1, 16'h7777, 1'b1);
        chk("midreset.filled", 32'(filled), 32'd0);
        chk("midreset.empty", 32'(empty), 32'd1);
        chk("midreset.rd", 32'(rd_data), 32'd0);
        cyc("post_reset_rd", 1'b0, 1'b0, '0, 1'b1);

        // sync2_ff with R=1
        scyc(1'b1);
        scyc(1'b1);
        srst = 1'b0;
        scyc(1'b1);
        chk("sync.q_reset", 32'(sq), 32'd1);
        chk("sync.pe_reset", 32'(spe), 32'd0);
        chk("sync.ne_reset", 32'(sne), 32'd0);
        scyc(1'b0);
        chk("sync.fall1.q", 32'(sq), 32'd1);
        chk("sync.fall1.ne", 32'(sne), 32'd0);
        scyc(1'b0);
        chk("sync.fall2.q", 32'(sq), 32'd0);
        chk("sync.fall2.ne", 32'(sne), 32'd1);
        scyc(1'b0);
        chk("sync.fall3.ne", 32'(sne), 32'd0);
        chk("sync.fall3.pe", 32'(spe), 32'd0);
        scyc(1'b1);
        chk("sync.rise1.q", 32'(sq), 32'd0);
        chk("sync.rise1.pe", 32'(spe), 32'd0);
        scyc(1'b1);
        chk("sync.rise2.q", 32'(sq), 32'd1);
        chk("sync.rise2.pe", 32'(spe), 32'd1);
        scyc(1'b1);
        chk("sync.rise3.pe", 32'(spe), 32'd0);
        chk("sync.rise3.ne", 32'(sne), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
